// File: rtl/tca9539_access_ctrl.sv
// Shares the TCA9539 register-file port between the I2C byte stream and a host.
// Define TCA9539_PAIR_WRAP_EN to make the command pointer toggle within its pair.
module tca9539_access_ctrl #(
  parameter int HOST_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_start,
  input  logic       i2c_wr_valid,
  input  logic [7:0] i2c_wr_data,
  input  logic       i2c_rd_req,
  output logic [7:0] i2c_rd_data,
  output logic       i2c_rd_valid,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [2:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic [7:0] rf_addr,
  output logic [7:0] rf_wdata,
  output logic       rf_we,
  input  logic [7:0] rf_rdata,
  output logic [2:0] ptr
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    HOST_WR,
    HOST_RD_ADDR,
    HOST_RD_WAIT
  } state_t;

  localparam int CW = (HOST_TIMEOUT > 1) ? $clog2(HOST_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((HOST_TIMEOUT > 0) ? HOST_TIMEOUT - 1 : 0);

  state_t        state;
  logic          cmdSeen;
  logic          cmdBad;
  logic          pendValid;
  logic          pendRd;
  logic [7:0]    pendData;
  logic          ovf;
  logic          hostBad;
  logic [2:0]    rfAddr;
  logic [CW-1:0] waitCnt;

  logic       newPulse;
  logic       srcValid;
  logic       srcRd;
  logic [7:0] srcData;
  logic       cmdSeenEff;
  logic       hostBusy;
  logic       grant;
  logic       waiting;

  assign rf_addr    = {5'b0, rfAddr};
  assign newPulse   = i2c_wr_valid | i2c_rd_req;
  assign srcValid   = pendValid | newPulse;
  assign srcRd      = pendValid ? pendRd : ~i2c_wr_valid;
  assign srcData    = pendValid ? pendData : i2c_wr_data;
  assign cmdSeenEff = cmdSeen & ~i2c_start;
  assign hostBusy   = state inside {HOST_WR, HOST_RD_ADDR, HOST_RD_WAIT};
  // host_req is ignored during its own ack cycle
  assign grant   = (state == IDLE) && !srcValid && host_req && !host_ack;
  assign waiting = host_req && !host_ack && !hostBusy && !grant;

  function automatic logic [2:0] advance(input logic [2:0] p);
`ifdef TCA9539_PAIR_WRAP_EN
    return {p[2:1], ~p[0]};
`else
    return p + 3'd1;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cmdSeen      <= 1'b0;
      cmdBad       <= 1'b0;
      pendValid    <= 1'b0;
      pendRd       <= 1'b0;
      pendData     <= '0;
      ovf          <= 1'b0;
      hostBad      <= 1'b0;
      rfAddr       <= '0;
      waitCnt      <= '0;
      rf_wdata     <= '0;
      rf_we        <= 1'b0;
      i2c_rd_data  <= '0;
      i2c_rd_valid <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      host_err     <= 1'b0;
    end else begin
      rf_we        <= 1'b0;
      i2c_rd_valid <= 1'b0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      if (i2c_start) cmdSeen <= 1'b0;

      // In IDLE the slot drains this cycle, so a fresh pulse refills it
      if (state == IDLE) begin
        if (pendValid) begin
          pendValid <= newPulse;
          if (newPulse) begin
            pendRd   <= ~i2c_wr_valid;
            pendData <= i2c_wr_data;
          end
        end
      end else if (newPulse) begin
        if (!pendValid) begin
          pendValid <= 1'b1;
          pendRd    <= ~i2c_wr_valid;
          pendData  <= i2c_wr_data;
        end else begin
          ovf <= 1'b1;
        end
      end

      if (!waiting) begin
        waitCnt <= '0;
      end else if (HOST_TIMEOUT != 0 && waitCnt == TO_LAST) begin
        waitCnt    <= '0;
        host_ack   <= 1'b1;
        host_err   <= 1'b1;
        host_rdata <= '0;
      end else begin
        waitCnt <= waitCnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (srcValid) begin
            if (!srcRd && !cmdSeenEff) begin
              ptr     <= srcData[2:0];
              cmdBad  <= |srcData[7:3];
              cmdSeen <= 1'b1;
            end else if (!srcRd) begin
              state    <= WR;
              rfAddr   <= ptr;
              rf_wdata <= srcData;
              rf_we    <= !ptr[2] && !cmdBad;
            end else begin
              state  <= RD_ADDR;
              rfAddr <= ptr;
            end
          end else if (grant) begin
            rfAddr <= host_addr;
            if (host_we) begin
              state    <= HOST_WR;
              rf_wdata <= host_wdata;
              rf_we    <= !host_addr[2];
              hostBad  <= host_addr[2];
            end else begin
              state <= HOST_RD_ADDR;
            end
          end
        end
        WR: begin
          ptr   <= advance(ptr);
          state <= IDLE;
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          i2c_rd_data  <= cmdBad ? 8'h00 : rf_rdata;
          i2c_rd_valid <= 1'b1;
          ptr          <= advance(ptr);
          state        <= IDLE;
        end
        HOST_WR: begin
          host_ack   <= 1'b1;
          host_err   <= hostBad;
          host_rdata <= '0;
          state      <= IDLE;
        end
        HOST_RD_ADDR: state <= HOST_RD_WAIT;
        HOST_RD_WAIT: begin
          host_rdata <= rf_rdata;
          host_ack   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow is sticky until reset
  assert property (@(posedge clk) disable iff (rst) ovf |=> ovf);

endmodule
